framebuffer_scanner: RTL and testbench

FRAMEBUFFER_SCANNER -- requirements
Module: framebuffer_scanner

---
 rtl/framebuffer_scanner_pkg.sv | 31 +++
 rtl/framebuffer_scanner_fifo.sv | 56 +++++
 rtl/framebuffer_scanner.sv | 126 ++++++++++++
 tb/tb_framebuffer_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_scanner_pkg.sv
// Shared data types for the framebuffer scanner: pixel format and the SRAM
// controller request/response records.
package framebuffer_scanner_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int PIXEL_W     = 16;

    typedef logic [SRAM_ADDR_W-1:0] SramAddress_t;
    typedef logic [SRAM_DATA_W-1:0] SramData_t;
    typedef logic [PIXEL_W-1:0]     Pixel_t;

    typedef struct packed {
        SramAddress_t address;
        SramData_t    dout;
        logic         oe_n;
        logic         we_n;
        logic         den;
    } SramRequest_t;

    typedef struct packed {
        logic      done;
        SramData_t din;
    } SramResult_t;

    // SRAM words carry the pixel in their low bits
    function automatic Pixel_t to_pixel(input SramData_t d);
        return Pixel_t'(d);
    endfunction

endpackage

// File: rtl/framebuffer_scanner_fifo.sv
// First-word fall-through pixel FIFO. A pop of a non-empty FIFO frees room for
// a push in the same cycle, so push+pop on a full FIFO is accepted.
module pixel_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/framebuffer_scanner.sv
// Framebuffer scanner: streams H_PIXELS*V_PIXELS words from SRAM into a
// prefetch FIFO that the display pipeline drains one pixel per pixelReq.
module framebuffer_scanner
    import framebuffer_scanner_pkg::*;
#(
    parameter int H_PIXELS   = 640,
    parameter int V_PIXELS   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frameStart,
    input  SramAddress_t baseAddress,
    input  SramResult_t  ramResult,
    output SramRequest_t ramRequest,
    input  logic         pixelReq,
    output Pixel_t       pixel,
    output logic         frameDone,
    output logic         underflow
);
    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT_SPACE, S_DONE} scan_state_t;

    scan_state_t  r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    SramRequest_t r_req;
    logic         r_frame_done;
    logic         r_underflow;

    logic          w_push;
    logic          w_pop_ok;
    logic          w_empty;
    logic          w_full;
    logic          w_last;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_count_next;
    Pixel_t        w_head;

    assign w_push   = (r_state == S_READ) && ramResult.done && !frameStart;
    assign w_pop_ok = pixelReq && !w_empty;
    assign w_last   = (r_x == XW'(H_PIXELS - 1)) && (r_y == YW'(V_PIXELS - 1));

    always_comb begin
        w_count_next = w_fifo_count;
        if (w_push && !w_pop_ok)      w_count_next = w_fifo_count + CW'(1);
        else if (!w_push && w_pop_ok) w_count_next = w_fifo_count - CW'(1);
    end

    pixel_fifo #(.WIDTH($bits(Pixel_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frameStart),
        .push  (w_push),
        .pop   (pixelReq),
        .din   (to_pixel(ramResult.din)),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_count)
    );

    // Scan order is linear in memory, so the request address simply steps by
    // one word per accepted read instead of recomputing base + y*H + x.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_req        <= '{address: '0, dout: '0, oe_n: 1'b1, we_n: 1'b1, den: 1'b0};
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (frameStart) begin
            r_state       <= S_READ;
            r_x           <= '0;
            r_y           <= '0;
            r_req.address <= baseAddress;
            r_req.den     <= 1'b1;
            r_req.oe_n    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (pixelReq && w_empty) r_underflow <= 1'b1;
            case (r_state)
                S_READ: begin
                    if (ramResult.done) begin
                        r_req.address <= r_req.address + SramAddress_t'(1);
                        if (r_x == XW'(H_PIXELS - 1)) begin
                            r_x <= '0;
                            r_y <= r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_req.den    <= 1'b0;
                            r_req.oe_n   <= 1'b1;
                            r_frame_done <= 1'b1;
                        end else if (w_count_next == CW'(FIFO_DEPTH)) begin
                            r_state    <= S_WAIT_SPACE;
                            r_req.den  <= 1'b0;
                            r_req.oe_n <= 1'b1;
                        end
                    end
                end
                S_WAIT_SPACE: begin
                    if (!w_full) begin
                        r_state    <= S_READ;
                        r_req.den  <= 1'b1;
                        r_req.oe_n <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ramRequest = r_req;
    assign pixel      = w_empty ? '0 : w_head;
    assign frameDone  = r_frame_done;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_framebuffer_scanner.sv
// Directed bench for framebuffer_scanner (4x2 frame, 4-entry FIFO) with a
// one-cycle-latency SRAM model, plus a standalone pixel_fifo instance.
`timescale 1ns/1ps
module tb_framebuffer_scanner;
    import framebuffer_scanner_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;
    localparam int SRAM_LAT = 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         frame_start;
    SramAddress_t base_address;
    SramResult_t  ram_result = '0;
    SramRequest_t ram_request;
    logic         pixel_req;
    Pixel_t       pixel;
    logic         frame_done;
    logic         underflow;

    framebuffer_scanner #(.H_PIXELS(H), .V_PIXELS(V), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .frameStart  (frame_start),
        .baseAddress (base_address),
        .ramResult   (ram_result),
        .ramRequest  (ram_request),
        .pixelReq    (pixel_req),
        .pixel       (pixel),
        .frameDone   (frame_done),
        .underflow   (underflow)
    );

    logic        f_push, f_pop, f_flush, f_full, f_empty;
    logic [15:0] f_din, f_dout;
    logic [2:0]  f_count;

    pixel_fifo #(.WIDTH(16), .DEPTH(4)) u_fifo_chk (
        .clk   (clk),
        .rst   (rst),
        .flush (f_flush),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    // scoreboard
    logic [15:0] exp_q[$];
    logic [19:0] addr_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int rd_idx;
    int sram_wait = 0;
    SramAddress_t sram_addr = '0;

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        return {a[7:0], ~a[7:0]} ^ 16'h0F30;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM model: done one cycle after a request appears; records accepted words
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            ram_result = '0;
            sram_wait  = 0;
        end else if (ram_result.done) begin
            if (frame_start) begin
                exp_q.delete();
                addr_q.delete();
            end else begin
                exp_q.push_back(ram_result.din);
                addr_q.push_back(sram_addr);
            end
            ram_result = '0;
            sram_wait  = ram_request.den ? 1 : 0;
        end else if (frame_start) begin
            exp_q.delete();
            addr_q.delete();
            sram_wait = ram_request.den ? 1 : 0;
        end else if (ram_request.den) begin
            sram_wait++;
            if (sram_wait > SRAM_LAT) begin
                ram_result.done = 1'b1;
                ram_result.din  = sram_word(ram_request.address);
                sram_addr       = ram_request.address;
            end
        end else begin
            sram_wait = 0;
        end
    end

    // driver tasks (called just after a falling edge)
    task automatic start_frame(input logic [19:0] base);
        frame_start  = 1'b1;
        base_address = base;
        rd_idx       = 0;
        @(negedge clk);
        frame_start  = 1'b0;
    endtask

    task automatic pulse_pixel_req();
        pixel_req = 1'b1;
        rd_idx++;
        @(negedge clk);
        pixel_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation budget expired");
        $fatal(1);
    end

    initial begin
        bit seen7, seen8;
        int n_before;

        rst = 1'b0; frame_start = 1'b0; base_address = '0; pixel_req = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_din = '0; rd_idx = 0;
        repeat (3) @(negedge clk);

        // reset values
        check_eq("rst_den",    32'(ram_request.den),     32'd0);
        check_eq("rst_oe_n",   32'(ram_request.oe_n),    32'd1);
        check_eq("rst_we_n",   32'(ram_request.we_n),    32'd1);
        check_eq("rst_addr",   32'(ram_request.address), 32'd0);
        check_eq("rst_dout",   32'(ram_request.dout),    32'd0);
        check_eq("rst_pixel",  32'(pixel),               32'd0);
        check_eq("rst_fdone",  32'(frame_done),          32'd0);
        check_eq("rst_uflow",  32'(underflow),           32'd0);

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_no_den",   32'(ram_request.den), 32'd0);
        check_eq("idle_no_reads", 32'(addr_q.size()),   32'd0);

        // fill to depth with pixelReq low, then one pop allows exactly one read
        start_frame(20'h100);
        repeat (30) @(negedge clk);
        check_eq("fill_reads", 32'(addr_q.size()),      32'd4);
        check_eq("fill_den",   32'(ram_request.den),    32'd0);
        check_eq("fill_count", 32'(dut.u_fifo.count),   32'(D));
        check_eq("fill_we_n",  32'(ram_request.we_n),   32'd1);
        check_eq("fill_head",  32'(pixel),              32'(sram_word(20'h100)));
        pulse_pixel_req();
        check_eq("pop_head", 32'(pixel), 32'(sram_word(20'h101)));
        repeat (20) @(negedge clk);
        check_eq("one_more_read", 32'(addr_q.size()),   32'd5);
        check_eq("wait_den",      32'(ram_request.den), 32'd0);

        // drain the rest of the frame, checking pixel order and frameDone timing
        seen7 = 1'b0; seen8 = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (addr_q.size() == 7 && !seen7) begin
                seen7 = 1'b1;
                check_eq("fdone_before_8th", 32'(frame_done), 32'd0);
            end
            if (addr_q.size() == 8 && !seen8) begin
                seen8 = 1'b1;
                check_eq("fdone_after_8th", 32'(frame_done), 32'd1);
            end
            if (frame_done && rd_idx == exp_q.size()) break;
            if (rd_idx < exp_q.size()) begin
                check_eq("drain_pixel", 32'(pixel), 32'(sram_word(20'(32'h100 + rd_idx))));
                pixel_req = 1'b1;
                rd_idx++;
            end else begin
                pixel_req = 1'b0;
            end
            @(negedge clk);
        end
        pixel_req = 1'b0;
        check_eq("frame_reads", 32'(addr_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check_eq("frame_addr", 32'(addr_q[i]), 32'(32'h100 + i));
        check_eq("frame_done",   32'(frame_done),      32'd1);
        check_eq("done_den",     32'(ram_request.den), 32'd0);
        check_eq("frame_uflow",  32'(underflow),       32'd0);

        // pixelReq on the first cycle of a frame hits an empty FIFO
        start_frame(20'h300);
        check_eq("uf_pixel", 32'(pixel), 32'd0);
        pixel_req = 1'b1;
        @(negedge clk);
        pixel_req = 1'b0;
        check_eq("uf_set", 32'(underflow), 32'd1);
        repeat (12) @(negedge clk);
        check_eq("uf_sticky", 32'(underflow), 32'd1);

        // abort mid-row (x=2, y=1) while a done is pending
        start_frame(20'h100);
        check_eq("uf_cleared", 32'(underflow), 32'd0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (addr_q.size() == 6 && ram_result.done) break;
            pixel_req = (rd_idx < exp_q.size());
            if (pixel_req) rd_idx++;
            @(negedge clk);
        end
        pixel_req = 1'b0;
        check_eq("midrow_done", 32'(ram_result.done),     32'd1);
        check_eq("midrow_addr", 32'(ram_request.address), 32'h106);
        start_frame(20'h200);
        check_eq("abort_count", 32'(dut.u_fifo.count),    32'd0);
        check_eq("abort_pixel", 32'(pixel),               32'd0);
        check_eq("abort_addr",  32'(ram_request.address), 32'h200);
        check_eq("abort_den",   32'(ram_request.den),     32'd1);
        repeat (2) @(negedge clk);
        check_eq("abort_first_pixel", 32'(pixel),            32'(sram_word(20'h200)));
        check_eq("abort_one_read",    32'(addr_q.size()),    32'd1);
        check_eq("abort_count1",      32'(dut.u_fifo.count), 32'd1);

        // asynchronous reset in the middle of a read
        #2 rst = 1'b0;
        #1;
        check_eq("arst_den",   32'(ram_request.den),     32'd0);
        check_eq("arst_oe_n",  32'(ram_request.oe_n),    32'd1);
        check_eq("arst_addr",  32'(ram_request.address), 32'd0);
        check_eq("arst_pixel", 32'(pixel),               32'd0);
        check_eq("arst_fdone", 32'(frame_done),          32'd0);
        n_before = addr_q.size();
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("arst_idle_den",   32'(ram_request.den), 32'd0);
        check_eq("arst_no_reads",   32'(addr_q.size()),   32'(n_before));

        // standalone FIFO: full + push + pop keeps count and loses nothing
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1;
            f_din  = 16'(32'hA000 + i);
            @(negedge clk);
        end
        f_push = 1'b0;
        check_eq("fifo_full",  32'(f_full),  32'd1);
        check_eq("fifo_cnt4",  32'(f_count), 32'd4);
        check_eq("fifo_head0", 32'(f_dout),  32'hA000);
        f_push = 1'b1; f_pop = 1'b1; f_din = 16'hA004;
        @(negedge clk);
        f_push = 1'b0; f_pop = 1'b0;
        check_eq("fifo_pp_cnt",  32'(f_count), 32'd4);
        check_eq("fifo_pp_head", 32'(f_dout),  32'hA001);
        for (int i = 1; i < 5; i++) begin
            check_eq("fifo_order", 32'(f_dout), 32'(32'hA000 + i));
            f_pop = 1'b1;
            @(negedge clk);
        end
        f_pop = 1'b0;
        check_eq("fifo_empty", 32'(f_empty), 32'd1);
        f_push = 1'b1; f_pop = 1'b1; f_din = 16'hB00B;
        @(negedge clk);
        f_push = 1'b0; f_pop = 1'b0;
        check_eq("fifo_empty_pp_cnt",  32'(f_count), 32'd1);
        check_eq("fifo_empty_pp_head", 32'(f_dout),  32'hB00B);
        f_flush = 1'b1;
        @(negedge clk);
        f_flush = 1'b0;
        check_eq("fifo_flush", 32'(f_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
